// File: rtl/rtc_pkg.sv
// Shared types, constants and BCD helpers for the RTC time setter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rtc_pkg;

    // Two-digit packed BCD: tens in [7:4], units in [3:0].
    typedef logic [7:0] bcd2_t;

    // FSM state encodings.
    typedef logic [2:0] state_t;
    localparam state_t IDLE     = 3'd0;
    localparam state_t SET_HOUR = 3'd1;
    localparam state_t SET_MIN  = 3'd2;
    localparam state_t SET_SEC  = 3'd3;
    localparam state_t COMMIT   = 3'd4;

    // field_sel encodings, consumed by the display blink logic.
    localparam logic [1:0] FS_NONE = 2'd0;
    localparam logic [1:0] FS_HOUR = 2'd1;
    localparam logic [1:0] FS_MIN  = 2'd2;
    localparam logic [1:0] FS_SEC  = 2'd3;

    localparam bcd2_t HOUR_MAX    = 8'h23;
    localparam bcd2_t MIN_SEC_MAX = 8'h59;

    // BCD +1 with wrap to 00 once max_v is reached.
    function automatic bcd2_t bcd_inc(input bcd2_t v, input bcd2_t max_v);
        if (v >= max_v)
            return 8'h00;
        if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Snapshot filter: anything that is not legal BCD or exceeds max_v
    // becomes 00. Valid BCD compares correctly as a plain binary number.
    function automatic bcd2_t bcd_sanitize(input bcd2_t v, input bcd2_t max_v);
        if (v[3:0] > 4'd9 || v[7:4] > 4'd9 || v > max_v)
            return 8'h00;
        return v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single-cycle press pulse: 2-flop synchronizer, debounce, rising-edge detect.
// Latency: 2 + DEBOUNCE_CYCLES clk cycles from raw edge to press_pulse.
// Backpressure: none; a held button gives exactly one pulse.
// Ports: clk, rst (sync, active-high), btn_raw (async input), press_pulse (1-cycle output).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1     <= 1'b0;
            sync_q2     <= 1'b0;
            level_q     <= 1'b0;
            cnt_q       <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_q1     <= btn_raw;
            sync_q2     <= sync_q1;
            press_pulse <= 1'b0;
            // cnt_q counts consecutive samples that disagree with the
            // accepted level; any agreeing sample restarts the run.
            if (sync_q2 == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q     <= sync_q2;
                cnt_q       <= '0;
                press_pulse <= sync_q2;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_time_setter.sv
// Button-driven editor for RTC hours/minutes/seconds; offers the edited time to the RTC over valid/ready.
// Latency: set_* update 1 cycle after a debounced press pulse; load completes on the load_valid && load_ready cycle.
// Backpressure: load_valid and set_* hold in COMMIT until load_ready; presses are ignored meanwhile.
// Ports: clk, rst (sync, active-high), btn_mode/btn_inc (raw buttons), cur_* (live BCD time),
//        set_* (edited BCD time), field_sel/editing (display), load_valid/load_ready (load handshake).
// Build option: define RTC_SET_TIMEOUT_EN to abandon an idle edit after TIMEOUT_CYCLES cycles.
module rtc_time_setter
    import rtc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [7:0] cur_hour,
    input  logic [7:0] cur_min,
    input  logic [7:0] cur_sec,
    output logic [7:0] set_hour,
    output logic [7:0] set_min,
    output logic [7:0] set_sec,
    output logic [1:0] field_sel,
    output logic       editing,
    output logic       load_valid,
    input  logic       load_ready
);

    logic   mode_pulse;
    logic   inc_pulse;
    logic   timed_out;
    state_t state_q;
    bcd2_t  hour_q;
    bcd2_t  min_q;
    bcd2_t  sec_q;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_mode),
        .press_pulse (mode_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_inc),
        .press_pulse (inc_pulse)
    );

`ifdef RTC_SET_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_q;
    logic          in_set;

    assign in_set    = (state_q == SET_HOUR) || (state_q == SET_MIN) || (state_q == SET_SEC);
    assign timed_out = in_set && (idle_cnt_q == TW'(TIMEOUT_CYCLES));

    // Every SET_* entry is caused by a mode pulse, so clearing on pulses
    // also clears on entry. Held at zero outside SET_* so COMMIT never expires.
    always_ff @(posedge clk) begin
        if (rst || mode_pulse || inc_pulse || !in_set)
            idle_cnt_q <= '0;
        else if (!timed_out)
            idle_cnt_q <= idle_cnt_q + TW'(1);
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timed_out          = 1'b0;
`endif

    // Mode is tested before inc in every SET_* state, so a coincident inc is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mode_pulse) begin
                        hour_q  <= bcd_sanitize(cur_hour, HOUR_MAX);
                        min_q   <= bcd_sanitize(cur_min, MIN_SEC_MAX);
                        sec_q   <= bcd_sanitize(cur_sec, MIN_SEC_MAX);
                        state_q <= SET_HOUR;
                    end
                end
                SET_HOUR: begin
                    if (mode_pulse)     state_q <= SET_MIN;
                    else if (inc_pulse) hour_q  <= bcd_inc(hour_q, HOUR_MAX);
                    else if (timed_out) state_q <= IDLE;
                end
                SET_MIN: begin
                    if (mode_pulse)     state_q <= SET_SEC;
                    else if (inc_pulse) min_q   <= bcd_inc(min_q, MIN_SEC_MAX);
                    else if (timed_out) state_q <= IDLE;
                end
                SET_SEC: begin
                    if (mode_pulse)     state_q <= COMMIT;
                    else if (inc_pulse) sec_q   <= bcd_inc(sec_q, MIN_SEC_MAX);
                    else if (timed_out) state_q <= IDLE;
                end
                COMMIT: begin
                    if (load_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        field_sel = FS_NONE;
        case (state_q)
            SET_HOUR: field_sel = FS_HOUR;
            SET_MIN:  field_sel = FS_MIN;
            SET_SEC:  field_sel = FS_SEC;
            default:  field_sel = FS_NONE;
        endcase
    end

    assign editing    = (field_sel != FS_NONE);
    assign load_valid = (state_q == COMMIT);
    assign set_hour   = hour_q;
    assign set_min    = min_q;
    assign set_sec    = sec_q;

endmodule

// File: tb/tb_rtc_time_setter.sv
// Self-checking bench for rtc_time_setter: table of edit sessions plus hand-written corner sequences.
// Latency: n/a (testbench).
// Backpressure: load_ready driven by the bench to exercise COMMIT stalls.
module tb_rtc_time_setter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [7:0] cur_hour = 8'h00;
    logic [7:0] cur_min = 8'h00;
    logic [7:0] cur_sec = 8'h00;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic [1:0] field_sel;
    logic       editing;
    logic       load_valid;
    logic       load_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    rtc_time_setter #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(50)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .set_hour   (set_hour),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .field_sel  (field_sel),
        .editing    (editing),
        .load_valid (load_valid),
        .load_ready (load_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch, cm, cs;   // live time at snapshot
        int         fld;          // mode presses after entry before incrementing (0=hour)
        int         ninc;         // inc presses on that field
        logic [7:0] sh, sm, ss;   // expected snapshot
        logic [7:0] eh, em, es;   // expected time offered for load
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Press and release with clean edges; long enough for both edges to debounce.
    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h12, 8'h34, 8'h56, 0, 3, 8'h12, 8'h34, 8'h56, 8'h15, 8'h34, 8'h56};
        vecs[1] = '{8'h23, 8'h00, 8'h00, 0, 1, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h10, 8'h59, 8'h30, 1, 1, 8'h10, 8'h59, 8'h30, 8'h10, 8'h00, 8'h30};
        vecs[3] = '{8'h01, 8'h02, 8'h09, 2, 1, 8'h01, 8'h02, 8'h09, 8'h01, 8'h02, 8'h10};
        vecs[4] = '{8'h2A, 8'h61, 8'h05, 2, 0, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h05};
        vecs[5] = '{8'h19, 8'h09, 8'h59, 0, 1, 8'h19, 8'h09, 8'h59, 8'h20, 8'h09, 8'h59};
        vecs[6] = '{8'h19, 8'h09, 8'h59, 2, 1, 8'h19, 8'h09, 8'h59, 8'h19, 8'h09, 8'h00};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_hour", set_hour, 8'h00);
        chk("rst_min", set_min, 8'h00);
        chk("rst_sec", set_sec, 8'h00);
        chk("rst_field", {6'd0, field_sel}, 8'd0);
        chk("rst_editing", {7'd0, editing}, 8'd0);
        chk("rst_valid", {7'd0, load_valid}, 8'd0);

        // inc in IDLE is ignored.
        press(1'b0, 1'b1);
        chk("idle_inc_editing", {7'd0, editing}, 8'd0);
        chk("idle_inc_hour", set_hour, 8'h00);

        // Table-driven edit sessions.
        foreach (vecs[v]) begin
            cur_hour = vecs[v].ch;
            cur_min  = vecs[v].cm;
            cur_sec  = vecs[v].cs;
            press(1'b1, 1'b0);
            chk($sformatf("v%0d_snap_hour", v), set_hour, vecs[v].sh);
            chk($sformatf("v%0d_snap_min", v), set_min, vecs[v].sm);
            chk($sformatf("v%0d_snap_sec", v), set_sec, vecs[v].ss);
            chk($sformatf("v%0d_field_hour", v), {6'd0, field_sel}, 8'd1);
            chk($sformatf("v%0d_editing", v), {7'd0, editing}, 8'd1);
            for (int k = 0; k < vecs[v].fld; k++) press(1'b1, 1'b0);
            chk($sformatf("v%0d_field", v), {6'd0, field_sel}, 8'(vecs[v].fld + 1));
            for (int k = 0; k < vecs[v].ninc; k++) press(1'b0, 1'b1);
            for (int k = vecs[v].fld; k < 3; k++) press(1'b1, 1'b0);
            chk($sformatf("v%0d_commit_valid", v), {7'd0, load_valid}, 8'd1);
            chk($sformatf("v%0d_commit_field", v), {6'd0, field_sel}, 8'd0);
            chk($sformatf("v%0d_load_hour", v), set_hour, vecs[v].eh);
            chk($sformatf("v%0d_load_min", v), set_min, vecs[v].em);
            chk($sformatf("v%0d_load_sec", v), set_sec, vecs[v].es);
            // Stall: load_valid must hold while load_ready is low.
            repeat (5) @(negedge clk);
            chk($sformatf("v%0d_stall_valid", v), {7'd0, load_valid}, 8'd1);
            load_ready = 1'b1;
            @(negedge clk);
            load_ready = 1'b0;
            chk($sformatf("v%0d_after_load_valid", v), {7'd0, load_valid}, 8'd0);
            chk($sformatf("v%0d_after_load_editing", v), {7'd0, editing}, 8'd0);
            chk($sformatf("v%0d_keep_hour", v), set_hour, vecs[v].eh);
            chk($sformatf("v%0d_keep_sec", v), set_sec, vecs[v].es);
        end

        // load_ready outside COMMIT has no effect; mode in COMMIT is ignored.
        cur_hour = 8'h05; cur_min = 8'h06; cur_sec = 8'h07;
        load_ready = 1'b1;
        press(1'b1, 1'b0);
        load_ready = 1'b0;
        chk("ready_outside_field", {6'd0, field_sel}, 8'd1);
        chk("ready_outside_valid", {7'd0, load_valid}, 8'd0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("commit_mode_ignored", {7'd0, load_valid}, 8'd1);

        // Reset mid-COMMIT: no load, everything cleared.
        do_reset();
        chk("midcommit_rst_valid", {7'd0, load_valid}, 8'd0);
        chk("midcommit_rst_field", {6'd0, field_sel}, 8'd0);
        chk("midcommit_rst_hour", set_hour, 8'h00);
        chk("midcommit_rst_min", set_min, 8'h00);
        chk("midcommit_rst_sec", set_sec, 8'h00);

        // Bounce: 10 cycles of chatter then a clean hold gives exactly one increment.
        press(1'b1, 1'b0);
        chk("bounce_snap_hour", set_hour, 8'h05);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            btn_inc = ~btn_inc;
        end
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (20) @(negedge clk);
        btn_inc = 1'b0;
        repeat (20) @(negedge clk);
        chk("bounce_one_inc", set_hour, 8'h06);

        // Coincident mode and inc: field advances, no increment.
        press(1'b1, 1'b1);
        chk("both_field", {6'd0, field_sel}, 8'd2);
        chk("both_hour", set_hour, 8'h06);
        chk("both_min", set_min, 8'h06);

        // Idle in SET_MIN: abandons when the timeout is built in, waits otherwise.
        begin
            logic saw_valid;
            saw_valid = 1'b0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (load_valid) saw_valid = 1'b1;
            end
            chk("idle_edit_no_valid", {7'd0, saw_valid}, 8'd0);
`ifdef RTC_SET_TIMEOUT_EN
            chk("timeout_editing", {7'd0, editing}, 8'd0);
            chk("timeout_keep_hour", set_hour, 8'h06);
            chk("timeout_keep_min", set_min, 8'h06);
`else
            chk("no_timeout_field", {6'd0, field_sel}, 8'd2);
            chk("no_timeout_editing", {7'd0, editing}, 8'd1);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
